// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display blocks.
//   SEG_A..SEG_G : bit positions of each segment in a 7-bit segment vector.
//                  Segment a is bit 6 and segment g is bit 0.
//   FONT         : hex glyphs 0..F, active-high, packed in abcdefg order.
//   scan_state_e : scanner slot phase (BLANK = anti-ghost gap, SHOW = digit on).
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] FONT [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_font_rom.sv
// ---------------------------------------------------------------------------
// seg7_font_rom
// Combinational hex-to-segment lookup with selectable output polarity.
// Parameters:
//   ACTIVE_LOW : 1 = a lit segment is driven 0.
// Ports:
//   i_val : 4-bit hex value to display.
//   o_seg : segments, bit 6 = a ... bit 0 = g, polarity applied.
// ---------------------------------------------------------------------------
module seg7_font_rom
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // The FONT table is packed assuming a..g occupy bits 6..0 in order; stop
  // elaboration if the segment index constants ever drift from that layout.
  generate
    if ((SEG_A != 6) || (SEG_B != 5) || (SEG_C != 4) || (SEG_D != 3) ||
        (SEG_E != 2) || (SEG_F != 1) || (SEG_G != 0)) begin : g_bad_layout
      $error("seg7_font_rom: segment index constants do not match FONT packing");
    end
  endgenerate

  logic [6:0] w_seg_hi;

  assign w_seg_hi = FONT[i_val];
  assign o_seg    = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed seven-segment scanner for NUM_DIGITS hex digits sharing one
// cathode bus. Each digit owns a slot of SLOT_CYCLES clocks: the first
// BLANK_CYCLES keep every anode off (anti-ghosting), the remainder show the
// digit gated by per-digit blanking and a global 16-step PWM brightness.
// The digit value, dp and blank flags are captured at slot start so input
// changes during a slot never tear the displayed glyph.
// Ports:
//   clk        : system clock.
//   rst        : synchronous reset, active-high.
//   digits     : digit i in bits [4i+3:4i].
//   dp_in      : decimal point request per digit.
//   blank_in   : 1 keeps digit i dark for its whole slot.
//   brightness : PWM duty, 0 = dark, 15 = always on (sampled live).
//   anode      : registered digit enables (polarity ANODE_ACTIVE_LOW).
//   cathode    : registered segments, bit6 = a .. bit0 = g (SEG_ACTIVE_LOW).
//   dp_out     : registered decimal point segment (SEG_ACTIVE_LOW).
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int SLOT_CYCLES      = 100000,
  parameter int BLANK_CYCLES     = 2000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp_out
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Per-digit inputs are padded to a power of two so a variable index by
  // r_idx can never address past the end of the array.
  localparam int PAD_N = 1 << IDX_W;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_e      ST_RESET   = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF     = SEG_ACTIVE_LOW;

  generate
    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 16)) begin : g_bad_num_digits
      $error("seven_seg_scan_ctrl: NUM_DIGITS must be in 1..16");
    end
    if ((BLANK_CYCLES < 0) || (SLOT_CYCLES <= BLANK_CYCLES)) begin : g_bad_slot
      $error("seven_seg_scan_ctrl: need 0 <= BLANK_CYCLES < SLOT_CYCLES");
    end
  endgenerate

  // State
  scan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_pwm;
  logic             r_first;      // first clock out of reset: load slot-0 snapshot
  logic [3:0]       r_snap_val;
  logic             r_snap_dp;
  logic             r_snap_blank;

  // Next-state / decode
  scan_state_e      w_state_next;
  logic             w_wrap;
  logic             w_load;
  logic             w_lit;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [6:0]       w_font_seg;

  logic [3:0]            w_digit_arr [PAD_N];
  logic [PAD_N-1:0]      w_dp_pad;
  logic [PAD_N-1:0]      w_blank_pad;
  logic [NUM_DIGITS-1:0] w_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < PAD_N; gi++) begin : g_pad
      if (gi < NUM_DIGITS) begin : g_real
        assign w_digit_arr[gi] = digits[4*gi +: 4];
        assign w_dp_pad[gi]    = dp_in[gi];
        assign w_blank_pad[gi] = blank_in[gi];
      end else begin : g_fill
        assign w_digit_arr[gi] = 4'h0;
        assign w_dp_pad[gi]    = 1'b0;
        assign w_blank_pad[gi] = 1'b1;
      end
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  seg7_font_rom #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_font (
    .i_val (r_snap_val),
    .o_seg (w_font_seg)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and lit decode
  always_comb begin
    w_wrap       = (r_cnt == CNT_LAST);
    w_cnt_next   = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    if (w_wrap) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
    // Snapshot at every slot boundary, plus once right after reset so the
    // reset slot shows digit 0 instead of the cleared snapshot.
    w_load       = w_wrap || r_first;
    w_state_next = r_state;
    case (r_state)
      BLANK: begin
        if (w_cnt_next == CNT_BLANK) begin
          w_state_next = SHOW;
        end
      end
      SHOW: begin
        if (w_wrap && (BLANK_CYCLES > 0)) begin
          w_state_next = BLANK;
        end
      end
      default: w_state_next = ST_RESET;
    endcase
    // brightness 15 must be always-on, which pwm < 15 alone cannot express.
    w_lit = (r_state == SHOW) && !r_snap_blank &&
            ((brightness == 4'hF) || (r_pwm < brightness));
  end

  // Counters, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pwm        <= '0;
      r_first      <= 1'b1;
      r_snap_val   <= '0;
      r_snap_dp    <= 1'b0;
      r_snap_blank <= 1'b0;
      anode        <= ANODE_OFF;
      cathode      <= SEG_OFF;
      dp_out       <= DP_OFF;
    end else begin
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_pwm   <= r_pwm + 4'd1;
      r_first <= 1'b0;
      if (w_load) begin
        r_snap_val   <= w_digit_arr[w_idx_next];
        r_snap_dp    <= w_dp_pad[w_idx_next];
        r_snap_blank <= w_blank_pad[w_idx_next];
      end
      // Cathode is forced off with the anode so the next digit never sees a
      // stale glyph on the shared bus.
      if (w_lit) begin
        anode   <= ANODE_ACTIVE_LOW ? ~w_onehot : w_onehot;
        cathode <= w_font_seg;
        dp_out  <= r_snap_dp ? ~DP_OFF : DP_OFF;
      end else begin
        anode   <= ANODE_OFF;
        cathode <= SEG_OFF;
        dp_out  <= DP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
// Two scanner instances share one clock:
//   u_dut   : 4 digits, 8-cycle slots, 2 blank cycles (scan/snapshot/control).
//   u_dut_b : 4 digits, 40-cycle slots, no blanking (brightness PWM).
// Stimulus pushes the hand-computed expected outputs for the next clock into
// a scoreboard queue; the monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b;
  logic [15:0] digits, digits_b;
  logic [3:0]  dp_in, blank_in, dp_in_b, blank_in_b;
  logic [3:0]  brightness, brightness_b;
  logic [3:0]  anode, anode_b;
  logic [6:0]  cathode, cathode_b;
  logic        dp_out, dp_out_b;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (4),
    .SLOT_CYCLES      (8),
    .BLANK_CYCLES     (2),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .brightness (brightness),
    .anode      (anode),
    .cathode    (cathode),
    .dp_out     (dp_out)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (4),
    .SLOT_CYCLES      (40),
    .BLANK_CYCLES     (0),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .digits     (digits_b),
    .dp_in      (dp_in_b),
    .blank_in   (blank_in_b),
    .brightness (brightness_b),
    .anode      (anode_b),
    .cathode    (cathode_b),
    .dp_out     (dp_out_b)
  );

  typedef struct {
    int         tgt;
    bit         sel;
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Hand-computed active-low glyphs for digits = 16'h3A71 (digit 0 first).
  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] cat_tab [4] = '{7'b1001111, 7'b0001111, 7'b0001000, 7'b0000110};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    while ((sb_q.size() > 0) && (sb_q[0].tgt <= cyc)) begin
      logic [3:0] a_an;
      logic [6:0] a_cat;
      logic       a_dp;
      mon_e = sb_q.pop_front();
      n_tests++;
      a_an  = mon_e.sel ? anode_b   : anode;
      a_cat = mon_e.sel ? cathode_b : cathode;
      a_dp  = mon_e.sel ? dp_out_b  : dp_out;
      if (mon_e.tgt != cyc) begin
        n_fail++;
        $display("FAIL %s: entry for cycle %0d checked at cycle %0d", mon_e.name, mon_e.tgt, cyc);
      end else if ((a_an !== mon_e.an) || (a_cat !== mon_e.cat) || (a_dp !== mon_e.dp)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: got anode=%b cathode=%b dp=%b, want anode=%b cathode=%b dp=%b",
                 mon_e.name, cyc, a_an, a_cat, a_dp, mon_e.an, mon_e.cat, mon_e.dp);
      end else begin
        $display("[TB] ok %s cyc=%0d anode=%b cathode=%b dp=%b", mon_e.name, cyc, a_an, a_cat, a_dp);
      end
    end
  end

  // One clock of stimulus: drive reset for the chosen DUT, queue the output
  // expected after the coming rising edge, then wait for the falling edge.
  task automatic step(input bit sel, input logic r, input logic [3:0] an,
                      input logic [6:0] cat, input logic dp, input string name);
    exp_t e;
    if (sel) rst_b = r;
    else     rst   = r;
    e.tgt  = cyc + 1;
    e.sel  = sel;
    e.an   = an;
    e.cat  = cat;
    e.dp   = dp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step_off(input bit sel, input logic r, input string name);
    step(sel, r, 4'b1111, 7'b1111111, 1'b1, name);
  endtask

  // k counts clocks since reset release on u_dut.
  task automatic scan_step(input int k, input string name);
    int s;
    int p;
    s = (k / 8) % 4;
    p = k % 8;
    if (p < 2) step_off(1'b0, 1'b0, name);
    else       step(1'b0, 1'b0, an_tab[s], cat_tab[s], 1'b1, name);
  endtask

  initial begin
    rst          = 1'b1;
    rst_b        = 1'b1;
    digits       = 16'h3A71;
    dp_in        = 4'b0000;
    blank_in     = 4'b0000;
    brightness   = 4'd15;
    digits_b     = 16'h0000;
    dp_in_b      = 4'b0000;
    blank_in_b   = 4'b0000;
    brightness_b = 4'd15;
    @(negedge clk);

    // Reset held
    for (int i = 0; i < 3; i++) step_off(1'b0, 1'b1, "reset_hold");

    // Full scan plus wrap back to digit 0
    for (int k = 0; k < 36; k++) scan_step(k, "scan");

    // Reset inside a SHOW window, then restart from digit 0
    step_off(1'b0, 1'b1, "mid_show_reset");
    for (int k = 0; k < 11; k++) scan_step(k, "restart");

    // Snapshot: digits change mid-SHOW of digit 0
    step_off(1'b0, 1'b1, "snap_reset");
    step_off(1'b0, 1'b1, "snap_reset");
    for (int k = 0; k < 4; k++) scan_step(k, "snap_pre");
    digits = 16'hFFFF;
    for (int k = 4; k < 8; k++) step(1'b0, 1'b0, 4'b1110, 7'b1001111, 1'b1, "snap_hold");
    step_off(1'b0, 1'b0, "snap_gap");
    step_off(1'b0, 1'b0, "snap_gap");
    for (int k = 10; k < 16; k++) step(1'b0, 1'b0, 4'b1101, 7'b0111000, 1'b1, "snap_next");
    digits = 16'h3A71;

    // Per-digit blanking (digit 1) and decimal point (digit 2)
    blank_in = 4'b0010;
    dp_in    = 4'b0100;
    step_off(1'b0, 1'b1, "ctl_reset");
    step_off(1'b0, 1'b1, "ctl_reset");
    for (int k = 0; k < 32; k++) begin
      int s;
      int p;
      s = k / 8;
      p = k % 8;
      if ((p < 2) || (s == 1)) step_off(1'b0, 1'b0, "blank_dp");
      else step(1'b0, 1'b0, an_tab[s], cat_tab[s], (s == 2) ? 1'b0 : 1'b1, "blank_dp");
    end
    blank_in = 4'b0000;
    dp_in    = 4'b0000;

    // Brightness 4: lit while pwm (= k mod 16) < 4
    brightness_b = 4'd4;
    step_off(1'b1, 1'b1, "pwm4_reset");
    step_off(1'b1, 1'b1, "pwm4_reset");
    for (int k = 0; k < 32; k++) begin
      if ((k % 16) < 4) step(1'b1, 1'b0, 4'b1110, 7'b0000001, 1'b1, "pwm4");
      else              step_off(1'b1, 1'b0, "pwm4");
    end

    // Brightness 0: never lit
    brightness_b = 4'd0;
    step_off(1'b1, 1'b1, "pwm0_reset");
    step_off(1'b1, 1'b1, "pwm0_reset");
    for (int k = 0; k < 16; k++) step_off(1'b1, 1'b0, "pwm0");

    // Brightness 15: continuously lit, digit 1 from the second slot
    brightness_b = 4'd15;
    step_off(1'b1, 1'b1, "pwm15_reset");
    step_off(1'b1, 1'b1, "pwm15_reset");
    for (int k = 0; k < 48; k++) begin
      step(1'b1, 1'b0, (k < 40) ? 4'b1110 : 4'b1101, 7'b0000001, 1'b1, "pwm15");
    end

    // Drain the scoreboard within a bounded number of clocks
    for (int i = 0; (i < 5) && (sb_q.size() > 0); i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
